// File: rtl/dm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dm_pkg
// Purpose  : Size codes, FSM encoding and limits for the data-memory responder
// Revision : 1.0
// ---------------------------------------------------------------------------
package dm_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  localparam logic [1:0] MEM_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_t;

  localparam int unsigned c_wait_max = 15;

endpackage : dm_pkg
`default_nettype wire

// File: rtl/dm_lane_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dm_lane_align
// Purpose  : Little-endian lane extract/extend for loads and lane merge for
//            stores. Misalign flag is active only with DM_ALIGN_CHECK_EN.
// Revision : 1.0
// ---------------------------------------------------------------------------
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  op,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] ld_data,
  output logic [31:0] st_word,
  output logic        misalign
);

  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte_sh = {addr_lo, 3'b000};
  assign w_half_sh = {addr_lo[1], 4'b0000};
  assign w_byte    = old_word[w_byte_sh +: 8];
  assign w_half    = old_word[w_half_sh +: 16];

  always_comb begin
    ld_data = 32'd0;
    case (op)
      MEM_BYTE: ld_data = {{24{w_byte[7] & ~is_unsigned}}, w_byte};
      MEM_HALF: ld_data = {{16{w_half[15] & ~is_unsigned}}, w_half};
      MEM_WORD: ld_data = old_word;
      default:  ld_data = 32'd0;
    endcase
  end

  // Only the addressed lanes take new data; the rest keep the old word.
  always_comb begin
    st_word = old_word;
    case (op)
      MEM_BYTE: st_word[w_byte_sh +: 8]  = wdata[7:0];
      MEM_HALF: st_word[w_half_sh +: 16] = wdata[15:0];
      MEM_WORD: st_word = wdata;
      default:  st_word = old_word;
    endcase
  end

`ifdef DM_ALIGN_CHECK_EN
  assign misalign = ((op == MEM_HALF) && addr_lo[0]) ||
                    ((op == MEM_WORD) && (addr_lo != 2'b00));
`else
  assign misalign = 1'b0;
`endif

endmodule : dm_lane_align
`default_nettype wire

// File: rtl/dm_resp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dm_resp
// Purpose  : Wait-stated data-memory responder with valid/ready handshakes.
//            Optional misalignment check: DM_ALIGN_CHECK_EN.
// Revision : 1.0
// ---------------------------------------------------------------------------
module dm_resp
  import dm_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_op,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         c_depth     = 1 << DEPTH_LOG2;
  localparam int         c_wait_eff  = (WAIT_CYCLES > int'(c_wait_max)) ? int'(c_wait_max) : WAIT_CYCLES;
  localparam logic [3:0] c_wait_load = (c_wait_eff == 0) ? 4'd0 : 4'(c_wait_eff - 1);

  dm_state_t             r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [1:0]            r_op;
  logic                  r_uns;
  logic [DEPTH_LOG2+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_mem [c_depth];

  logic                  w_accept;
  logic                  w_access;
  logic                  w_acc_we;
  logic [1:0]            w_acc_op;
  logic                  w_acc_uns;
  logic [DEPTH_LOG2+1:0] w_acc_addr;
  logic [31:0]           w_acc_wdata;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           w_old_word;
  logic [31:0]           w_ld_data;
  logic [31:0]           w_st_word;
  logic                  w_misalign;
  logic                  w_err;
  logic [31:0]           w_rsp_data;
  logic                  w_mem_we;
  logic                  w_unused_addr;

  assign req_ready     = (r_state == ST_IDLE) && !rst;
  assign w_accept      = req_valid && req_ready;
  assign w_unused_addr = ^req_addr[31:DEPTH_LOG2+2];

  // With no wait states the access happens on the accept edge itself, so it
  // must see the live request rather than the latched copy.
  generate
    if (c_wait_eff == 0) begin : g_direct
      assign w_access    = w_accept;
      assign w_acc_we    = req_we;
      assign w_acc_op    = req_op;
      assign w_acc_uns   = req_unsigned;
      assign w_acc_addr  = req_addr[DEPTH_LOG2+1:0];
      assign w_acc_wdata = req_wdata;
    end else begin : g_latched
      assign w_access    = (r_state == ST_WAIT) && (r_cnt == 4'd0);
      assign w_acc_we    = r_we;
      assign w_acc_op    = r_op;
      assign w_acc_uns   = r_uns;
      assign w_acc_addr  = r_addr;
      assign w_acc_wdata = r_wdata;
    end
  endgenerate

  assign w_idx      = w_acc_addr[DEPTH_LOG2+1:2];
  assign w_old_word = r_mem[w_idx];

  dm_lane_align u_lane_align (
    .op          (w_acc_op),
    .is_unsigned (w_acc_uns),
    .addr_lo     (w_acc_addr[1:0]),
    .wdata       (w_acc_wdata),
    .old_word    (w_old_word),
    .ld_data     (w_ld_data),
    .st_word     (w_st_word),
    .misalign    (w_misalign)
  );

  assign w_err      = (w_acc_op == MEM_RSVD) || w_misalign;
  assign w_rsp_data = (w_acc_we || w_err) ? 32'd0 : w_ld_data;
  assign w_mem_we   = w_access && w_acc_we && !w_err && !rst;

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_st_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_op      <= MEM_BYTE;
      r_uns     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_op    <= req_op;
            r_uns   <= req_unsigned;
            r_addr  <= req_addr[DEPTH_LOG2+1:0];
            r_wdata <= req_wdata;
            if (c_wait_eff == 0) begin
              r_state   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= w_rsp_data;
              rsp_err   <= w_err;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= c_wait_load;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state   <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= w_rsp_data;
            rsp_err   <= w_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state   <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : dm_resp
`default_nettype wire

// File: tb/tb_dm_resp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_dm_resp
// Purpose  : Directed plus randomized checks of dm_resp against a byte-level
//            memory model.
// Revision : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dm_resp;
  import dm_pkg::*;

  localparam int DEPTH_LOG2  = 10;
  localparam int WAIT_CYCLES = 2;
  localparam int MEM_BYTES   = 4 << DEPTH_LOG2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_op;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ref_mem [int];

  dm_resp #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_op       (req_op),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Byte-addressed little-endian memory; sizes are 1/2/4 bytes at a naturally
  // rounded-down base, wrapping modulo the memory size.
  function automatic void model(input logic we, input logic [1:0] op, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
    int a, n, base;
    logic [31:0] v;
    rdata = 32'd0;
    err   = 1'b0;
    if (op == 2'b11) begin
      err = 1'b1;
      return;
    end
    a = int'(addr % 32'(MEM_BYTES));
    n = (op == 2'b00) ? 1 : (op == 2'b01) ? 2 : 4;
`ifdef DM_ALIGN_CHECK_EN
    if ((a % n) != 0) begin
      err = 1'b1;
      return;
    end
`endif
    base = a - (a % n);
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[base + i] = wdata[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | ({24'd0, ref_mem[base + i]} << (8 * i));
      if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rdata = v;
    end
  endfunction

  task automatic txn(input string tag, input logic we, input logic [1:0] op, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                     output logic [31:0] got);
    logic [31:0] exp_d;
    logic        exp_e;
    int          guard;
    int          n;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
    model(we, op, uns, addr, wdata, exp_d, exp_e);
    req_valid    = 1'b1;
    req_we       = we;
    req_op       = op;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, WAIT_CYCLES + 1);
    chk({tag, "_data"}, rsp_rdata, exp_d);
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_e});
    got = rsp_rdata;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk({tag, "_hold"}, rsp_rdata, exp_d);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    logic        rw;
    logic [1:0]  rop;
    logic        runs;
    logic [31:0] raddr;
    int          n;
    int          seen;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    txn("sw100", 1'b1, MEM_WORD, 1'b0, 32'h100, 32'h1122_3344, 0, got);
    txn("lw100", 1'b0, MEM_WORD, 1'b0, 32'h100, 32'd0, 0, got);
    chk("lw100_lit", got, 32'h1122_3344);
    txn("lb103", 1'b0, MEM_BYTE, 1'b0, 32'h103, 32'd0, 0, got);
    chk("lb103_lit", got, 32'h0000_0011);
    txn("sb101", 1'b1, MEM_BYTE, 1'b0, 32'h101, 32'h0000_00AA, 0, got);
    txn("lw100b", 1'b0, MEM_WORD, 1'b0, 32'h100, 32'd0, 0, got);
    chk("lw100b_lit", got, 32'h1122_AA44);
    txn("lb101", 1'b0, MEM_BYTE, 1'b0, 32'h101, 32'd0, 0, got);
    chk("lb101_lit", got, 32'hFFFF_FFAA);
    txn("lbu101", 1'b0, MEM_BYTE, 1'b1, 32'h101, 32'd0, 0, got);
    chk("lbu101_lit", got, 32'h0000_00AA);
    txn("sh102", 1'b1, MEM_HALF, 1'b0, 32'h102, 32'h0000_8001, 0, got);
    txn("lh102", 1'b0, MEM_HALF, 1'b0, 32'h102, 32'd0, 0, got);
    chk("lh102_lit", got, 32'hFFFF_8001);
    txn("lhu102", 1'b0, MEM_HALF, 1'b1, 32'h102, 32'd0, 0, got);
    chk("lhu102_lit", got, 32'h0000_8001);
    txn("lw100c", 1'b0, MEM_WORD, 1'b0, 32'h100, 32'd0, 0, got);
    chk("lw100c_lit", got, 32'h8001_AA44);

    // Backpressure: req_valid stays high across the whole response.
    req_valid = 1'b1; req_we = 1'b0; req_op = MEM_WORD; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'd0;
    @(posedge clk); #1;
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_lat", n, WAIT_CYCLES + 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_rdata, 32'h8001_AA44);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_after_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_after_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_reaccept", {31'd0, req_ready}, 32'd0);
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp2_lat", n, WAIT_CYCLES + 1);
    chk("bp2_data", rsp_rdata, 32'h8001_AA44);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    txn("rsvd_st", 1'b1, MEM_RSVD, 1'b0, 32'h100, 32'hCAFE_BABE, 0, got);
    txn("lw100d", 1'b0, MEM_WORD, 1'b0, 32'h100, 32'd0, 0, got);
    chk("lw100d_lit", got, 32'h8001_AA44);
    txn("lw102", 1'b0, MEM_WORD, 1'b0, 32'h102, 32'd0, 0, got);
`ifndef DM_ALIGN_CHECK_EN
    chk("lw102_lit", got, 32'h8001_AA44);
`endif

    // Reset during WAIT discards the pending store.
    txn("sw200", 1'b1, MEM_WORD, 1'b0, 32'h200, 32'h0BAD_F00D, 0, got);
    req_valid = 1'b1; req_we = 1'b1; req_op = MEM_WORD; req_addr = 32'h200;
    req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_wait_ready", {31'd0, req_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_ready2", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_release", {31'd0, req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("mid_rst_no_rsp", seen, 0);
    txn("lw200", 1'b0, MEM_WORD, 1'b0, 32'h200, 32'd0, 0, got);
    chk("lw200_lit", got, 32'h0BAD_F00D);
    txn("lw200w", 1'b0, MEM_WORD, 1'b0, 32'h200 + 32'(MEM_BYTES), 32'd0, 0, got);
    chk("lw200w_lit", got, 32'h0BAD_F00D);

    // Randomized traffic over a pre-initialized window, with aliased addresses.
    for (int i = 0; i < 16; i++)
      txn("rinit", 1'b1, MEM_WORD, 1'b0, 32'h300 + 32'(4 * i), $urandom, 0, got);
    for (int i = 0; i < 60; i++) begin
      rw    = 1'($urandom_range(0, 1));
      rop   = 2'($urandom_range(0, 3));
      runs  = 1'($urandom_range(0, 1));
      raddr = 32'h300 + 32'($urandom_range(0, 63)) + 32'($urandom_range(0, 3) * MEM_BYTES);
      txn($sformatf("rand%0d", i), rw, rop, runs, raddr, $urandom, int'($urandom_range(0, 3)), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_dm_resp
`default_nettype wire
